// File: rtl/mage_reg_pkg.sv
// Register-bus request/response types shared by the Mage register file and its initiators.
package mage_reg_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/mage_cfg_loader.sv
// Streams header-framed config bursts into the Mage register file, with optional
// read-back verification, bus-wait timeout and a classified error report.
module mage_cfg_loader
    import mage_reg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        verify_en_i,
    input  logic        cfg_valid_i,
    output logic        cfg_ready_o,
    input  logic [31:0] cfg_data_i,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] err_addr_o,
    output logic [15:0] words_o
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_WR   = 3'd3,
        ST_RD   = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    // Abort decision is taken on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 2);

    localparam logic [1:0] ERR_BUS     = 2'd1;
    localparam logic [1:0] ERR_VERIFY  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    function automatic logic [31:0] word_addr(input logic [15:0] off, input logic [15:0] idx);
        word_addr = BASE_ADDR + {16'h0000, off} + {14'h0000, idx, 2'b00};
    endfunction

    state_t            state_r;
    state_t            state_next_s;
    logic [15:0]       cnt_r;
    logic [15:0]       off_r;
    logic [15:0]       idx_r;
    logic [31:0]       wdata_r;
    logic [31:0]       addr_r;
    logic              write_r;
    logic              valid_r;
    logic              cfg_ready_r;
    logic              busy_r;
    logic              done_r;
    logic              verify_r;
    logic [1:0]        err_code_r;
    logic [31:0]       err_addr_r;
    logic [15:0]       words_r;
    logic [WAIT_W-1:0] wait_r;

    logic              hs_s;
    logic              last_s;
    logic              commit_s;
    logic              err_set_s;
    logic [1:0]        err_val_s;

    assign hs_s   = cfg_valid_i & cfg_ready_r;
    assign last_s = (idx_r == (cnt_r - 16'd1));

    // Next-state and event decode for the burst sequencer.
    always_comb begin
        state_next_s = state_r;
        commit_s     = 1'b0;
        err_set_s    = 1'b0;
        err_val_s    = 2'd0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) state_next_s = ST_HDR;
                else         state_next_s = ST_IDLE;
            end
            ST_HDR: begin
                if (hs_s) begin
                    if (cfg_data_i[31:16] == 16'd0) state_next_s = ST_FIN;
                    else                            state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_HDR;
                end
            end
            ST_LOAD: begin
                if (hs_s) state_next_s = ST_WR;
                else      state_next_s = ST_LOAD;
            end
            ST_WR, ST_RD: begin
                if (reg_rsp_i.ready) begin
                    if (reg_rsp_i.error) begin
                        err_set_s    = 1'b1;
                        err_val_s    = ERR_BUS;
                        state_next_s = ST_FIN;
                    end else if ((state_r == ST_WR) && verify_r) begin
                        state_next_s = ST_RD;
                    end else if ((state_r == ST_RD) && (reg_rsp_i.rdata != wdata_r)) begin
                        err_set_s    = 1'b1;
                        err_val_s    = ERR_VERIFY;
                        state_next_s = ST_FIN;
                    end else begin
                        commit_s     = 1'b1;
                        state_next_s = last_s ? ST_FIN : ST_LOAD;
                    end
                end else if (wait_r == WAIT_LAST) begin
                    err_set_s    = 1'b1;
                    err_val_s    = ERR_TIMEOUT;
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_FIN:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_r <= ST_IDLE;
        else          state_r <= state_next_s;
    end

    // Datapath, status and registered bus/stream outputs (decoded from the next state).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_r       <= 16'd0;
            off_r       <= 16'd0;
            idx_r       <= 16'd0;
            wdata_r     <= 32'd0;
            addr_r      <= 32'd0;
            write_r     <= 1'b0;
            valid_r     <= 1'b0;
            cfg_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            verify_r    <= 1'b0;
            err_code_r  <= 2'd0;
            err_addr_r  <= 32'd0;
            words_r     <= 16'd0;
            wait_r      <= '0;
        end else begin
            valid_r     <= (state_next_s == ST_WR) || (state_next_s == ST_RD);
            write_r     <= (state_next_s == ST_WR);
            cfg_ready_r <= (state_next_s == ST_HDR) || (state_next_s == ST_LOAD);
            busy_r      <= (state_next_s == ST_HDR) || (state_next_s == ST_LOAD) ||
                           (state_next_s == ST_WR)  || (state_next_s == ST_RD);
            done_r      <= (state_next_s == ST_FIN);

            if (valid_r && !reg_rsp_i.ready) wait_r <= wait_r + WAIT_W'(1);
            else                             wait_r <= '0;

            if ((state_r == ST_IDLE) && start_i) begin
                err_code_r <= 2'd0;
                err_addr_r <= 32'd0;
                words_r    <= 16'd0;
                idx_r      <= 16'd0;
                verify_r   <= verify_en_i;
            end
            if ((state_r == ST_HDR) && hs_s) begin
                cnt_r <= cfg_data_i[31:16];
                off_r <= {cfg_data_i[15:2], 2'b00};
            end
            if ((state_r == ST_LOAD) && hs_s) begin
                wdata_r <= cfg_data_i;
                addr_r  <= word_addr(off_r, idx_r);
            end
            if (err_set_s) begin
                err_code_r <= err_val_s;
                err_addr_r <= addr_r;
            end
            if (commit_s) begin
                if (words_r != 16'hFFFF) words_r <= words_r + 16'd1;
                idx_r <= idx_r + 16'd1;
            end
        end
    end

    assign reg_req_o = '{addr: addr_r, write: write_r, wdata: wdata_r, wstrb: 4'hF, valid: valid_r};

    assign cfg_ready_o = cfg_ready_r;
    assign busy_o      = busy_r;
    assign done_o      = done_r;
    assign err_code_o  = err_code_r;
    assign err_addr_o  = err_addr_r;
    assign words_o     = words_r;

endmodule

// File: tb/tb_mage_cfg_loader.sv
// Directed bench for mage_cfg_loader: stream source and register-file slave models
// around the DUT, with hand-computed expectations checked by immediate assertions.
module tb_mage_cfg_loader;
    import mage_reg_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          TMO  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        verify_en = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [31:0] cfg_data = 32'h0;
    logic        cfg_ready;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [31:0] err_addr;
    logic [15:0] words;
    reg_req_t    req;
    reg_rsp_t    rsp = '0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mage_cfg_loader #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .verify_en_i(verify_en),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_data_i(cfg_data),
        .reg_req_o(req), .reg_rsp_i(rsp), .busy_o(busy), .done_o(done),
        .err_code_o(err_code), .err_addr_o(err_addr), .words_o(words)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Stream source: main pushes words, this process presents and pops them.
    logic [31:0] sdata [0:127];
    int s_wr = 0, s_rd = 0, s_skip = 0;
    bit stream_rand = 1'b0;

    always @(negedge clk) begin
        logic v;
        if (s_rd < s_skip) s_rd = s_skip;
        v = (s_wr > s_rd) && (!stream_rand || ($urandom_range(0, 3) != 0));
        cfg_valid = v;
        cfg_data  = v ? sdata[s_rd] : 32'h0;
        if (v && cfg_ready) s_rd++;
    end

    // Register-file slave with ready/error/rdata fault injection and request-stability check.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] wlog_a [$];
    logic [31:0] wlog_d [$];
    int wr_count = 0, rd_count = 0, valid_cycles = 0;
    int ready_mode = 0, stall_after = 0, inj_wr = -1, bad_rd = -1;
    bit prev_stall = 1'b0;
    reg_req_t prev_req = '0;

    always @(negedge clk) begin
        logic rdy;
        if (prev_stall && req.valid) chk("req_stable", 32'(req === prev_req), 32'd1);
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'b0;
            2:       rdy = ($urandom_range(0, 3) != 0);
            default: rdy = (wr_count < stall_after);
        endcase
        rsp.ready = rdy;
        rsp.error = req.valid && req.write && (wr_count == inj_wr);
        rsp.rdata = (req.valid && !req.write && (rd_count == bad_rd)) ? 32'h0000_DEAD :
                    (mem.exists(req.addr) ? mem[req.addr] : 32'h0);
        if (req.valid) valid_cycles++;
        if (req.valid && rdy) begin
            if (req.write) begin
                if (!rsp.error) begin
                    mem[req.addr] = req.wdata;
                    wlog_a.push_back(req.addr);
                    wlog_d.push_back(req.wdata);
                end
                wr_count++;
            end else begin
                rd_count++;
            end
        end
        prev_stall = req.valid && !rdy;
        prev_req   = req;
    end

    task automatic push(input logic [31:0] w);
        sdata[s_wr] = w;
        s_wr++;
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        chk({tag, "_addr"}, (idx < wlog_a.size()) ? wlog_a[idx] : 32'hFFFF_FFFF, a);
        chk({tag, "_data"}, (idx < wlog_d.size()) ? wlog_d[idx] : 32'hFFFF_FFFF, d);
    endtask

    // Start a burst, count negedges until done, then confirm done is a single pulse.
    task automatic run_burst(input logic ven, input int restart_at, output int lat,
                             output logic bs, output logic [1:0] e1);
        lat = 0; bs = 1'b0; e1 = 2'd0;
        verify_en = ven;
        start = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            lat++;
            start = (lat == restart_at);
            if (lat == 1) begin
                bs = busy;
                e1 = err_code;
            end
            if (done) break;
        end
        chk("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("done_single", 32'(done), 32'd0);
        chk("idle_after", 32'(busy), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_err_addr"}, err_addr, 32'd0);
        chk({tag, "_words"}, 32'(words), 32'd0);
        chk({tag, "_req_valid"}, 32'(req.valid), 32'd0);
        chk({tag, "_req_addr"}, req.addr, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int lat, wb, vc, bc;
        logic bs;
        logic [1:0] e1;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // T1: three words, no verify
        wb = wlog_a.size();
        push(32'h0003_0010); push(32'hA0A0_0001); push(32'hB0B0_0002); push(32'hC0C0_0003);
        run_burst(1'b0, 0, lat, bs, e1);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_busy", 32'(bs), 32'd1);
        chk("t1_words", 32'(words), 32'd3);
        chk("t1_err", 32'(err_code), 32'd0);
        chk("t1_nwr", 32'(wlog_a.size() - wb), 32'd3);
        chk_wr("t1_w0", wb + 0, 32'h0000_0110, 32'hA0A0_0001);
        chk_wr("t1_w1", wb + 1, 32'h0000_0114, 32'hB0B0_0002);
        chk_wr("t1_w2", wb + 2, 32'h0000_0118, 32'hC0C0_0003);

        // T2: empty burst, start pulsed again in FIN
        bc = wr_count + rd_count; vc = valid_cycles;
        push(32'h0000_0040);
        run_burst(1'b0, 2, lat, bs, e1);
        chk("t2_latency", 32'(lat), 32'd2);
        chk("t2_words", 32'(words), 32'd0);
        chk("t2_err", 32'(err_code), 32'd0);
        chk("t2_no_xfer", 32'(wr_count + rd_count - bc), 32'd0);
        chk("t2_no_valid", 32'(valid_cycles - vc), 32'd0);

        // T3: verify mismatch on the second read-back
        bad_rd = rd_count + 1;
        push(32'h0003_0020); push(32'h0000_1234); push(32'h0000_BEEF); push(32'h0000_5678);
        run_burst(1'b1, 0, lat, bs, e1);
        chk("t3_latency", 32'(lat), 32'd8);
        chk("t3_err", 32'(err_code), 32'd2);
        chk("t3_err_addr", err_addr, 32'h0000_0124);
        chk("t3_words", 32'(words), 32'd1);
        chk("t3_left", 32'(s_wr - s_rd), 32'd1);
        chk("t3_mem", mem.exists(32'h0000_0124) ? mem[32'h0000_0124] : 32'h0, 32'h0000_BEEF);
        bad_rd = -1;
        s_skip = s_wr;

        // T4: slave never ready -> timeout
        ready_mode = 1; vc = valid_cycles;
        push(32'h0001_0000); push(32'h0000_0055);
        run_burst(1'b0, 0, lat, bs, e1);
        chk("t4_latency", 32'(lat), 32'd10);
        chk("t4_valid_cycles", 32'(valid_cycles - vc), 32'(TMO - 1));
        chk("t4_err", 32'(err_code), 32'd3);
        chk("t4_err_addr", err_addr, 32'h0000_0100);
        chk("t4_valid_drop", 32'(req.valid), 32'd0);
        ready_mode = 0;

        // T5: bus error on the first write, then a clean burst
        inj_wr = wr_count;
        push(32'h0002_0008); push(32'h0000_0001); push(32'h0000_0002);
        run_burst(1'b0, 0, lat, bs, e1);
        chk("t5_latency", 32'(lat), 32'd4);
        chk("t5_err", 32'(err_code), 32'd1);
        chk("t5_err_addr", err_addr, 32'h0000_0108);
        chk("t5_words", 32'(words), 32'd0);
        chk("t5_left", 32'(s_wr - s_rd), 32'd1);
        inj_wr = -1;
        s_skip = s_wr;
        push(32'h0001_000C); push(32'h0000_CAFE);
        run_burst(1'b0, 0, lat, bs, e1);
        chk("t5b_err_cleared", 32'(e1), 32'd0);
        chk("t5b_latency", 32'(lat), 32'd4);
        chk("t5b_err", 32'(err_code), 32'd0);
        chk("t5b_words", 32'(words), 32'd1);
        chk("t5b_mem", mem.exists(32'h0000_010C) ? mem[32'h0000_010C] : 32'h0, 32'h0000_CAFE);

        // Offset low bits forced to zero
        wb = wlog_a.size();
        push(32'h0002_FFFE); push(32'h0000_0011); push(32'h0000_0022);
        run_burst(1'b0, 0, lat, bs, e1);
        chk("off_latency", 32'(lat), 32'd6);
        chk("off_words", 32'(words), 32'd2);
        chk_wr("off_w0", wb + 0, 32'h0001_00FC, 32'h0000_0011);
        chk_wr("off_w1", wb + 1, 32'h0001_0100, 32'h0000_0022);

        // T6: reset while the second write is stalled
        ready_mode = 3; stall_after = wr_count + 1;
        push(32'h0002_0000); push(32'h7777_0001); push(32'h7777_0002);
        verify_en = 1'b0;
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if ((words == 16'd1) && req.valid) break;
        end
        chk("t6_stalled", 32'(req.valid), 32'd1);
        chk("t6_words_pre", 32'(words), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("t6_async");
        @(negedge clk);
        ready_mode = 0;
        s_skip = s_wr;
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("t6_post");
        wb = wlog_a.size();
        push(32'h0002_0030); push(32'h0000_0A01); push(32'h0000_0A02);
        run_burst(1'b0, 0, lat, bs, e1);
        chk("t6_latency", 32'(lat), 32'd6);
        chk("t6_words", 32'(words), 32'd2);
        chk("t6_err", 32'(err_code), 32'd0);
        chk_wr("t6_w0", wb + 0, 32'h0000_0130, 32'h0000_0A01);
        chk_wr("t6_w1", wb + 1, 32'h0000_0134, 32'h0000_0A02);

        // Random backpressure on both sides, verify on, start pulsed while busy
        stream_rand = 1'b1; ready_mode = 2;
        wb = wlog_a.size(); bc = rd_count;
        push(32'h0004_0200); push(32'h1111_0000); push(32'h2222_0001);
        push(32'h3333_0002); push(32'h4444_0003);
        run_burst(1'b1, 3, lat, bs, e1);
        chk("rnd_err", 32'(err_code), 32'd0);
        chk("rnd_words", 32'(words), 32'd4);
        chk("rnd_reads", 32'(rd_count - bc), 32'd4);
        chk_wr("rnd_w0", wb + 0, 32'h0000_0300, 32'h1111_0000);
        chk_wr("rnd_w1", wb + 1, 32'h0000_0304, 32'h2222_0001);
        chk_wr("rnd_w2", wb + 2, 32'h0000_0308, 32'h3333_0002);
        chk_wr("rnd_w3", wb + 3, 32'h0000_030C, 32'h4444_0003);
        stream_rand = 1'b0; ready_mode = 0;
        repeat (3) @(negedge clk);
        chk("rnd_stays_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
